// File: rtl/psx_mem_arbiter.sv
// psx_mem_arbiter: two-requester front end for the DDR-bridge client port.
// Each requester owns one pending slot. A three-state FSM (IDLE, ISSUE,
// WAIT_DONE) grants one slot at a time, issues a single registered command
// and waits for the bridge to finish before the next grant.
//
// Handshake: a requester pulses i_cmdN for one cycle only while o_busyN=0.
// o_busyN stays high from the cycle after the pulse until the cycle after its
// transaction completes. The bridge is ready when i_busyClient=0. A read
// completes when the bridge is not busy and i_dataValidClient=1, and a write
// completes when the bridge is not busy. The owner's o_dataValidN pulses in
// that same cycle.
//
// Build option: define PSX_MEM_ARB_FIXED_PRIO_EN to give R0 fixed priority
// over R1. When it is undefined, arbitration is round-robin.
// o_dbgState exposes the FSM state (0=IDLE, 1=ISSUE, 2=WAIT_DONE).

module psx_mem_arbiter (
    input  logic         i_clk,
    input  logic         i_nRst,

    input  logic         i_cmd0,
    input  logic         i_write0,
    input  logic [1:0]   i_size0,
    input  logic [14:0]  i_adr0,
    input  logic [2:0]   i_subAdr0,
    input  logic [15:0]  i_mask0,
    input  logic [255:0] i_data0,
    output logic         o_busy0,
    output logic         o_dataValid0,
    output logic [255:0] o_data0,

    input  logic         i_cmd1,
    input  logic         i_write1,
    input  logic [1:0]   i_size1,
    input  logic [14:0]  i_adr1,
    input  logic [2:0]   i_subAdr1,
    input  logic [15:0]  i_mask1,
    input  logic [255:0] i_data1,
    output logic         o_busy1,
    output logic         o_dataValid1,
    output logic [255:0] o_data1,

    output logic         o_command,
    output logic         o_writeElseRead,
    output logic [1:0]   o_commandSize,
    output logic [14:0]  o_targetAddr,
    output logic [2:0]   o_subAddr,
    output logic [15:0]  o_writeMask,
    output logic [255:0] o_dataClient,
    input  logic         i_busyClient,
    input  logic         i_dataValidClient,
    input  logic [255:0] i_dataClient,

    output logic [1:0]   o_dbgState
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } stateT;

    typedef struct packed {
        logic         write;
        logic [1:0]   size;
        logic [14:0]  adr;
        logic [2:0]   subAdr;
        logic [15:0]  mask;
        logic [255:0] data;
    } slotT;

    stateT state;
    stateT stateNext;

    slotT  slot0;
    slotT  slot1;
    slotT  grantSlot;

    logic  pend0;
    logic  pend1;
    logic  pendNext0;
    logic  pendNext1;

    // ownerId: 0 = R0, 1 = R1; valid from grant until completion
    logic  ownerValid;
    logic  ownerId;
    logic  ownerValidNext;
    logic  ownerIdNext;

    // low during the first WAIT_DONE cycle, before the bridge has raised busy
    logic  waitSeen;

    logic  grantEn;
    logic  grantSel;
    logic  done;

    // Read data is forwarded straight through; o_dataValidN qualifies it.
    assign o_data0 = i_dataClient;
    assign o_data1 = i_dataClient;

    // Capture all request fields on the requester's command pulse.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (i_cmd0) begin
                slot0 <= '{write: i_write0, size: i_size0, adr: i_adr0,
                           subAdr: i_subAdr0, mask: i_mask0, data: i_data0};
            end
            if (i_cmd1) begin
                slot1 <= '{write: i_write1, size: i_size1, adr: i_adr1,
                           subAdr: i_subAdr1, mask: i_mask1, data: i_data1};
            end
        end
    end

`ifdef PSX_MEM_ARB_FIXED_PRIO_EN
    // Fixed priority: R0 wins whenever it is pending.
    always_comb begin
        grantEn   = (pend0 | pend1) & ~i_busyClient;
        grantSel  = ~pend0;
        grantSlot = grantSel ? slot1 : slot0;
    end
`else
    // rrPrefer1 is 1 when R1 should win the next contested grant.
    logic rrPrefer1;

    // Round-robin: a contested grant goes to the requester not served last.
    always_comb begin
        grantEn   = (pend0 | pend1) & ~i_busyClient;
        grantSel  = (pend0 & pend1) ? rrPrefer1 : ~pend0;
        grantSlot = grantSel ? slot1 : slot0;
    end

    // Move the round-robin pointer only when a grant is actually made.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            rrPrefer1 <= 1'b0;
        end else if (state == IDLE && grantEn) begin
            rrPrefer1 <= ~grantSel;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (grantEn) stateNext = ISSUE;
            ISSUE:     stateNext = WAIT_DONE;
            WAIT_DONE: if (done) stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    // FSM outputs: completion detect, per-requester read-valid strobes, debug state.
    always_comb begin
        done         = (state == WAIT_DONE) & waitSeen & ~i_busyClient &
                       (o_writeElseRead | i_dataValidClient);
        o_dataValid0 = done & ~o_writeElseRead & ~ownerId;
        o_dataValid1 = done & ~o_writeElseRead &  ownerId;
        o_dbgState   = state;
    end

    // Mark the cycles in WAIT_DONE after the first one.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            waitSeen <= 1'b0;
        end else begin
            waitSeen <= (state == WAIT_DONE);
        end
    end

    // Next pending and ownership: set on request, clear on issue or completion.
    always_comb begin
        pendNext0 = pend0;
        pendNext1 = pend1;
        if (state == ISSUE) begin
            if (ownerId) begin
                pendNext1 = 1'b0;
            end else begin
                pendNext0 = 1'b0;
            end
        end
        if (i_cmd0) pendNext0 = 1'b1;
        if (i_cmd1) pendNext1 = 1'b1;

        ownerValidNext = ownerValid;
        ownerIdNext    = ownerId;
        if (state == IDLE && grantEn) begin
            ownerValidNext = 1'b1;
            ownerIdNext    = grantSel;
        end else if (done) begin
            ownerValidNext = 1'b0;
        end
    end

    // Pending bits, owner and the registered busy flags.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            pend0      <= 1'b0;
            pend1      <= 1'b0;
            ownerValid <= 1'b0;
            ownerId    <= 1'b0;
            o_busy0    <= 1'b0;
            o_busy1    <= 1'b0;
        end else begin
            pend0      <= pendNext0;
            pend1      <= pendNext1;
            ownerValid <= ownerValidNext;
            ownerId    <= ownerIdNext;
            o_busy0    <= pendNext0 | (ownerValidNext & ~ownerIdNext);
            o_busy1    <= pendNext1 | (ownerValidNext &  ownerIdNext);
        end
    end

    // Downstream command: one-cycle strobe in ISSUE; fields hold until the next grant.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            o_command       <= 1'b0;
            o_writeElseRead <= 1'b0;
            o_commandSize   <= 2'd0;
            o_targetAddr    <= 15'd0;
            o_subAddr       <= 3'd0;
            o_writeMask     <= 16'd0;
            o_dataClient    <= 256'd0;
        end else begin
            o_command <= (state == IDLE) & grantEn;
            if (state == IDLE && grantEn) begin
                o_writeElseRead <= grantSlot.write;
                o_commandSize   <= grantSlot.size;
                o_targetAddr    <= grantSlot.adr;
                o_subAddr       <= grantSlot.subAdr;
                o_writeMask     <= grantSlot.mask;
                o_dataClient    <= grantSlot.data;
            end
        end
    end

endmodule

// File: tb/tb_psx_mem_arbiter.sv
// Testbench for psx_mem_arbiter: directed requests, a simple bridge model,
// and a scoreboard monitor that checks commands and read returns.
// The bridge model raises busy one cycle after a command and holds it for
// three cycles. It then drops busy and, for reads, returns the inverted write
// data in that same cycle.

module tb_psx_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_nRst;
    always #5 i_clk = ~i_clk;

    // ---------------- DUT signals ----------------
    logic         i_cmd0, i_write0, i_cmd1, i_write1;
    logic [1:0]   i_size0, i_size1;
    logic [14:0]  i_adr0, i_adr1;
    logic [2:0]   i_subAdr0, i_subAdr1;
    logic [15:0]  i_mask0, i_mask1;
    logic [255:0] i_data0, i_data1;
    logic         o_busy0, o_busy1, o_dataValid0, o_dataValid1;
    logic [255:0] o_data0, o_data1;
    logic         o_command, o_writeElseRead;
    logic [1:0]   o_commandSize;
    logic [14:0]  o_targetAddr;
    logic [2:0]   o_subAddr;
    logic [15:0]  o_writeMask;
    logic [255:0] o_dataClient;
    logic         i_busyClient, i_dataValidClient;
    logic [255:0] i_dataClient;
    logic [1:0]   o_dbgState;

    // bridge model drives br*, directed tests drive force*/man*
    logic         brBusy, brValid, forceBusy, manValid, bridgeAuto;
    logic [255:0] brData, manData;
    assign i_busyClient      = brBusy | forceBusy;
    assign i_dataValidClient = brValid | manValid;
    assign i_dataClient      = brData | manData;

    psx_mem_arbiter dut (
        .i_clk(i_clk), .i_nRst(i_nRst),
        .i_cmd0(i_cmd0), .i_write0(i_write0), .i_size0(i_size0), .i_adr0(i_adr0),
        .i_subAdr0(i_subAdr0), .i_mask0(i_mask0), .i_data0(i_data0),
        .o_busy0(o_busy0), .o_dataValid0(o_dataValid0), .o_data0(o_data0),
        .i_cmd1(i_cmd1), .i_write1(i_write1), .i_size1(i_size1), .i_adr1(i_adr1),
        .i_subAdr1(i_subAdr1), .i_mask1(i_mask1), .i_data1(i_data1),
        .o_busy1(o_busy1), .o_dataValid1(o_dataValid1), .o_data1(o_data1),
        .o_command(o_command), .o_writeElseRead(o_writeElseRead),
        .o_commandSize(o_commandSize), .o_targetAddr(o_targetAddr),
        .o_subAddr(o_subAddr), .o_writeMask(o_writeMask), .o_dataClient(o_dataClient),
        .i_busyClient(i_busyClient), .i_dataValidClient(i_dataValidClient),
        .i_dataClient(i_dataClient), .o_dbgState(o_dbgState)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int fails  = 0;
    logic [292:0] expCmd0[$];
    logic [292:0] expCmd1[$];
    logic [255:0] expData0[$];
    logic [255:0] expData1[$];
    int           expGrant[$];

    task automatic chk(input string name, input logic [299:0] got, input logic [299:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [292:0] mk(input logic w, input logic [1:0] sz, input logic [14:0] adr,
                                        input logic [2:0] sub, input logic [15:0] mask,
                                        input logic [255:0] data);
        return {w, sz, adr, sub, mask, data};
    endfunction

    // monitor: pop and compare whenever the DUT presents a command or read data
    int           monGrant;
    logic [292:0] monExp;
    always @(negedge i_clk) begin
        if (i_nRst === 1'b1) begin
            if (o_command) begin
                if (expGrant.size() == 0) begin
                    chk("unexpected command", {299'd0, o_command}, 300'd0);
                end else begin
                    monGrant = expGrant.pop_front();
                    monExp = '1;
                    if (monGrant == 0 && expCmd0.size() != 0) monExp = expCmd0.pop_front();
                    if (monGrant == 1 && expCmd1.size() != 0) monExp = expCmd1.pop_front();
                    chk("command fields", {7'd0, o_writeElseRead, o_commandSize, o_targetAddr,
                                           o_subAddr, o_writeMask, o_dataClient}, {7'd0, monExp});
                end
            end
            if (o_dataValid0) begin
                if (expData0.size() == 0) chk("unexpected dataValid0", {299'd0, o_dataValid0}, 300'd0);
                else chk("read data R0", {44'd0, o_data0}, {44'd0, expData0.pop_front()});
            end
            if (o_dataValid1) begin
                if (expData1.size() == 0) chk("unexpected dataValid1", {299'd0, o_dataValid1}, 300'd0);
                else chk("read data R1", {44'd0, o_data1}, {44'd0, expData1.pop_front()});
            end
        end
    end

    // ---------------- bridge model ----------------
    logic         brWrite;
    logic [255:0] brCmdData;
    initial begin
        brBusy = 1'b0; brValid = 1'b0; brData = '0;
        forever begin
            @(negedge i_clk);
            if (o_command && bridgeAuto && i_nRst) begin
                brWrite = o_writeElseRead;
                brCmdData = o_dataClient;
                @(posedge i_clk); #1 brBusy = 1'b1;
                repeat (3) @(posedge i_clk);
                #1 brBusy = 1'b0;
                brValid = ~brWrite;
                brData = brWrite ? '0 : ~brCmdData;
                @(posedge i_clk); #1 brValid = 1'b0; brData = '0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int n, input logic w, input logic [1:0] sz, input logic [14:0] adr,
                         input logic [2:0] sub, input logic [15:0] mask, input logic [255:0] data);
        int k = 0;
        @(posedge i_clk); #1;
        while (((n == 0) ? o_busy0 : o_busy1) && k < 300) begin
            @(posedge i_clk); #1;
            k++;
        end
        if ((n == 0) ? o_busy0 : o_busy1) begin
            chk("request slot timeout", {299'd0, ((n == 0) ? o_busy0 : o_busy1)}, 300'd0);
        end else if (n == 0) begin
            i_cmd0 = 1'b1; i_write0 = w; i_size0 = sz; i_adr0 = adr;
            i_subAdr0 = sub; i_mask0 = mask; i_data0 = data;
            expCmd0.push_back(mk(w, sz, adr, sub, mask, data));
            @(posedge i_clk); #1 i_cmd0 = 1'b0;
        end else begin
            i_cmd1 = 1'b1; i_write1 = w; i_size1 = sz; i_adr1 = adr;
            i_subAdr1 = sub; i_mask1 = mask; i_data1 = data;
            expCmd1.push_back(mk(w, sz, adr, sub, mask, data));
            @(posedge i_clk); #1 i_cmd1 = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((expGrant.size() != 0 || o_busy0 || o_busy1 || i_busyClient || i_dataValidClient)
               && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        chk("drain timeout", {297'd0, expGrant.size() != 0, o_busy0, o_busy1}, 300'd0);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic doReset();
        @(posedge i_clk); #1;
        i_nRst = 1'b0;
        forceBusy = 1'b0; manValid = 1'b0; manData = '0;
        @(negedge i_clk);
        chk("outputs in reset", {o_command, o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr,
                                 o_writeMask, o_dataClient, o_busy0, o_busy1, o_dataValid0,
                                 o_dataValid1, o_dbgState}, 300'd0);
        chk("read data in reset", {44'd0, o_data0 | o_data1}, 300'd0);
        @(posedge i_clk); #1 i_nRst = 1'b1;
        @(negedge i_clk);
        chk("idle after reset", {296'd0, o_busy0, o_busy1, o_command, o_dbgState != 2'd0}, 300'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed test sequence ----------------
    int k;
    initial begin
        i_nRst = 1'b0;
        i_cmd0 = 0; i_write0 = 0; i_size0 = 0; i_adr0 = 0; i_subAdr0 = 0; i_mask0 = 0; i_data0 = 0;
        i_cmd1 = 0; i_write1 = 0; i_size1 = 0; i_adr1 = 0; i_subAdr1 = 0; i_mask1 = 0; i_data1 = 0;
        forceBusy = 0; manValid = 0; manData = '0; bridgeAuto = 1'b1;
        doReset();

        // simultaneous R0 write / R1 read from reset pointer: R0 first
        expGrant.push_back(0); expGrant.push_back(1);
        expData1.push_back({8{32'hEDCBA987}});
        fork
            issue(0, 1'b1, 2'd1, 15'h0100, 3'd0, 16'hF0F0, {8{32'hA5A50001}});
            issue(1, 1'b0, 2'd0, 15'h0200, 3'd2, 16'h0000, {8{32'h12345678}});
        join
        drain();

        // R0 read 32B, adr 0x0012: command two cycles after the request
        expGrant.push_back(0);
        expData0.push_back({64{4'hA}});
        issue(0, 1'b0, 2'd1, 15'h0012, 3'd0, 16'h0000, {64{4'h5}});
        @(negedge i_clk);
        chk("busy0 after request", {298'd0, o_busy0, o_command}, {298'd0, 2'b10});
        @(negedge i_clk);
        chk("command latency", {299'd0, o_command}, {299'd0, 1'b1});
        drain();

        // last grant was R0, so a contested grant goes to R1 first
        expGrant.push_back(1); expGrant.push_back(0);
        expData0.push_back({8{32'hF0F0F0F0}});
        fork
            issue(0, 1'b0, 2'd2, 15'h0300, 3'd5, 16'h0000, {8{32'h0F0F0F0F}});
            issue(1, 1'b1, 2'd0, 15'h0400, 3'd1, 16'hFFFF, {8{32'h5A5A5A5A}});
        join
        drain();

        // bridge busy holds R1 off; command follows the cycle after busy falls
        @(posedge i_clk); #1 forceBusy = 1'b1;
        expGrant.push_back(1);
        issue(1, 1'b1, 2'd1, 15'h7FFF, 3'd7, 16'h8001, {8{32'h01234567}});
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            chk("held off by bridge busy", {298'd0, o_busy1, o_command}, {298'd0, 2'b10});
        end
        @(posedge i_clk); #1 forceBusy = 1'b0;
        @(negedge i_clk);
        chk("no command as busy falls", {299'd0, o_command}, 300'd0);
        @(negedge i_clk);
        chk("command after busy falls", {299'd0, o_command}, {299'd0, 1'b1});
        drain();

        // R1 write 4B, sub 3, mask 0x0003; busy1 falls the cycle after bridge busy
        expGrant.push_back(1);
        issue(1, 1'b1, 2'd2, 15'h0055, 3'd3, 16'h0003, {8{32'hC0FFEE00}});
        k = 0;
        while (!i_busyClient && k < 50) begin @(negedge i_clk); k++; end
        while (i_busyClient && k < 100) begin @(negedge i_clk); k++; end
        chk("busy1 at write completion", {299'd0, o_busy1}, {299'd0, 1'b1});
        @(negedge i_clk);
        chk("busy1 after write completion", {299'd0, o_busy1}, 300'd0);
        drain();

        // from reset pointer, both re-requesting: R0,R1,R0,R1
        doReset();
        expGrant.push_back(0); expGrant.push_back(1);
        expGrant.push_back(0); expGrant.push_back(1);
        expData1.push_back({8{32'hCCCCCCCC}});
        expData1.push_back({8{32'hBBBBBBBB}});
        fork
            begin
                issue(0, 1'b1, 2'd1, 15'h0011, 3'd0, 16'h00FF, {8{32'h00000011}});
                issue(0, 1'b1, 2'd1, 15'h0022, 3'd0, 16'hFF00, {8{32'h00000022}});
            end
            begin
                issue(1, 1'b0, 2'd1, 15'h0033, 3'd0, 16'h0000, {8{32'h33333333}});
                issue(1, 1'b0, 2'd1, 15'h0044, 3'd0, 16'h0000, {8{32'h44444444}});
            end
        join
        drain();

        // reset during an R0 read in WAIT_DONE, then a late data-valid
        bridgeAuto = 1'b0;
        expGrant.push_back(0);
        issue(0, 1'b0, 2'd1, 15'h0500, 3'd0, 16'h0000, {8{32'h0BADF00D}});
        k = 0;
        while (!o_command && k < 20) begin @(negedge i_clk); k++; end
        @(posedge i_clk); #1 forceBusy = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("in WAIT_DONE before reset", {298'd0, o_dbgState}, {298'd0, 2'd2});
        doReset();
        @(posedge i_clk); #1 manValid = 1'b1; manData = {8{32'hDEADBEEF}};
        @(negedge i_clk);
        chk("late data valid ignored", {297'd0, o_dataValid0, o_dataValid1, o_command}, 300'd0);
        @(posedge i_clk); #1 manValid = 1'b0; manData = '0;
        bridgeAuto = 1'b1;
        repeat (3) @(negedge i_clk);

        chk("leftover expected grants", 300'(expGrant.size()), 300'd0);
        chk("leftover expected read data", 300'(expData0.size() + expData1.size()), 300'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/psx_mem_arbiter.md
PSX_MEM_ARBITER -- requirements
Module: psx_mem_arbiter

Interface
REQ-001 SHALL have no parameters; the requester count is fixed at 2 (R0, R1).
REQ-002 i_clk  input  1  single clock, rising edge.
REQ-003 i_nRst  input  1  reset, asynchronous, active-low.
REQ-004 i_cmd0 / i_cmd1  input  1  one-cycle request pulse, only while own o_busyN=0.
REQ-005 i_write0 / i_write1  input  1  0=read, 1=write.
REQ-006 i_size0 / i_size1  input  2  0=8 byte, 1=32 byte, 2=4 byte.
REQ-007 i_adr0 / i_adr1  input  15  32-byte block address.
REQ-008 i_subAdr0 / i_subAdr1  input  3  4-byte word within block.
REQ-009 i_mask0 / i_mask1  input  16  write mask, 1 bit per 16 bits.
REQ-010 i_data0 / i_data1  input  256  write data.
REQ-011 o_busy0 / o_busy1  output  1  requester slot occupied.
REQ-012 o_dataValid0 / o_dataValid1  output  1  read data pulse for that requester.
REQ-013 o_data0 / o_data1  output  256  read data, direct copy of i_dataClient.
REQ-014 o_command, o_writeElseRead, o_commandSize[1:0], o_targetAddr[14:0], o_subAddr[2:0], o_writeMask[15:0], o_dataClient[255:0]  outputs  downstream DDR-bridge client command, all registered.
REQ-015 i_busyClient  input  1; i_dataValidClient  input  1; i_dataClient  input  256: downstream bridge status and read return.

Function
REQ-016 SHALL hold one pending slot per requester; an i_cmdN pulse SHALL latch all fields of requester N and set pendingN on the next edge.
REQ-017 o_busyN SHALL equal pendingN OR (in-flight owner == N); it is registered and rises the cycle after i_cmdN.
REQ-018 States: IDLE, ISSUE, WAIT_DONE.
REQ-019 IDLE: if any pendingN and i_busyClient=0, grant one requester and go to ISSUE; otherwise stay.
REQ-020 ISSUE: o_command=1 for exactly one cycle, carrying the granted slot's fields; the granted pending bit clears; go to WAIT_DONE.
REQ-021 WAIT_DONE: ignore the first cycle, because the bridge raises busy one cycle after the command; afterwards, completion is i_busyClient=0 AND (write OR i_dataValidClient=1); on completion go to IDLE.
REQ-022 On a read completion, o_dataValidN of the owner SHALL pulse in the same cycle as i_dataValidClient; the other requester's valid stays 0.
REQ-023 The owner's o_busyN SHALL fall the cycle after completion; the requester may pulse i_cmdN in that cycle.
REQ-024 Earliest path: request pulse at cycle T, then o_command at T+2; the next command can issue at the earliest 2 cycles after completion.
REQ-025 Arbitration is round-robin: when both slots are pending, the requester not granted last wins; the pointer updates only on a grant.
REQ-026 Simultaneous i_cmd0 and i_cmd1 SHALL both latch; R0 wins if the pointer is at reset value.
REQ-027 A request from N arriving while the other requester is in flight SHALL wait in its slot, with no loss.
REQ-028 i_dataValidClient outside WAIT_DONE SHALL be ignored, with no valid pulse to either requester.
REQ-029 o_command SHALL never assert while i_busyClient=1 was sampled in IDLE.
REQ-030 Fields pass unmodified; the arbiter performs no size or mask reformatting.

Reset
REQ-031 i_nRst=0 SHALL asynchronously force: state IDLE, pending0/1=0, pointer=R0 preferred, o_command=0, o_busy0/1=0, o_dataValid0/1=0, all other registered outputs 0.
REQ-032 Reset mid-transaction SHALL drop the in-flight ownership and any pending request; a subsequent late i_dataValidClient SHALL produce no pulse.

Configuration
REQ-033 Macro PSX_MEM_ARB_FIXED_PRIO_EN: when defined, R0 always wins when both slots are pending, and the pointer logic is removed.
REQ-034 When the macro is undefined, round-robin per REQ-025 applies.

Verification
REQ-035 R0 read 32B, adr=0x0012 sub=0; bridge returns data 0xAA..AA -> o_command once with adr 0x0012 and size 1; o_dataValid0 pulses with o_data0=0xAA..AA; o_dataValid1 stays 0.
REQ-036 i_cmd0 write and i_cmd1 read in the same cycle -> R0 write issues first, then R1 read; with PSX_MEM_ARB_FIXED_PRIO_EN and R0 re-requesting immediately, R0 issues again and R1 waits.
REQ-037 Back-to-back round-robin, both requesters re-requesting continuously for 4 grants -> grant order R0,R1,R0,R1 (round-robin build).
REQ-038 i_busyClient held 1 for 10 cycles while R1 is pending -> no o_command until the cycle after busy falls plus IDLE; o_busy1=1 throughout.
REQ-039 R1 write 4B, sub=3, mask=0x0003 -> downstream subAddr=3, writeMask=0x0003, data unchanged; o_busy1 falls the cycle after i_busyClient falls.
REQ-040 Assert i_nRst=0 during R0 read WAIT_DONE, then pulse i_dataValidClient after release -> no o_dataValid0; all outputs are 0 during reset.
